// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the CPU, the NIC, the data memory and the port arbiter.
// The arbiter connects through the slave modport; the surrounding node uses master.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              nic_req;
    logic              nic_lock;
    logic              nic_we;
    logic [ADDR_W-1:0] nic_addr;
    logic [DATA_W-1:0] nic_wdata;
    logic              nic_gnt;
    logic              nic_rvalid;
    logic [DATA_W-1:0] nic_rdata;

    logic              mem_en;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  nic_req, nic_lock, nic_we, nic_addr, nic_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output nic_gnt, nic_rvalid, nic_rdata,
        output mem_en, mem_wren, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output nic_req, nic_lock, nic_we, nic_addr, nic_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  nic_gnt, nic_rvalid, nic_rdata,
        input  mem_en, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the NIC,
// with bounded NIC burst lock, read-data return steering and a CPU stall counter.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_port_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]      cpu_wait_cnt_o
);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, NIC_BURST} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_NIC} owner_e;

    state_e             state_q, state_d;
    logic               prio_nic_q, prio_nic_d;
    logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    owner_e             rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic               cpu_gnt, nic_gnt, cpu_stall;
    logic [BCNT_W-1:0]  burst_inc;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB;
            prio_nic_q  <= 1'b0;
            burst_cnt_q <= '0;
            rd_owner_q  <= OWN_NONE;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_nic_q  <= prio_nic_d;
            burst_cnt_q <= burst_cnt_d;
            rd_owner_q  <= rd_owner_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign burst_inc = burst_cnt_q + 1'b1;
    assign cpu_stall = bus.cpu_req & ~cpu_gnt;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        prio_nic_d  = prio_nic_q;
        burst_cnt_d = burst_cnt_q;
        rd_owner_d  = OWN_NONE;
        unique case (state_q)
            ARB: begin
                if (cpu_gnt) prio_nic_d = 1'b1;
                if (nic_gnt) begin
                    prio_nic_d = 1'b0;
                    if (bus.nic_lock && MAX_BURST > 1) begin
                        state_d     = NIC_BURST;
                        burst_cnt_d = BCNT_W'(1);
                    end
                end
            end
            NIC_BURST: begin
                // Leaving the burst always hands the next contended slot to the CPU.
                if (!bus.nic_req || !bus.nic_lock || burst_inc == BCNT_W'(MAX_BURST)) begin
                    state_d     = ARB;
                    prio_nic_d  = 1'b0;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_inc;
                end
            end
            default: ;
        endcase
        if (cpu_gnt && !bus.cpu_we) rd_owner_d = OWN_CPU;
        if (nic_gnt && !bus.nic_we) rd_owner_d = OWN_NIC;
        wait_cnt_d = (cpu_stall && wait_cnt_q != '1) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    end

    always_comb begin
        cpu_gnt = 1'b0;
        nic_gnt = 1'b0;
        unique case (state_q)
            ARB: begin
                if (bus.cpu_req && bus.nic_req) begin
                    cpu_gnt = ~prio_nic_q;
                    nic_gnt = prio_nic_q;
                end else begin
                    cpu_gnt = bus.cpu_req;
                    nic_gnt = bus.nic_req;
                end
            end
            NIC_BURST: begin
                nic_gnt = bus.nic_req;
                cpu_gnt = bus.cpu_req & ~bus.nic_req;
            end
            default: ;
        endcase

        bus.mem_wren  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_wren  = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (nic_gnt) begin
            bus.mem_wren  = bus.nic_we;
            bus.mem_addr  = bus.nic_addr;
            bus.mem_wdata = bus.nic_wdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.nic_gnt    = nic_gnt;
    assign bus.cpu_stall  = cpu_stall;
    assign bus.mem_en     = cpu_gnt | nic_gnt;
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.nic_rvalid = (rd_owner_q == OWN_NIC);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.nic_rdata  = bus.mem_rdata;
    assign cpu_wait_cnt_o = wait_cnt_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: expected grants per step, read returns
// through a scoreboard queue, and a saturating model of the CPU wait counter.
module tb_dmem_port_arbiter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    typedef struct {
        logic              is_nic;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] wait_cnt;
    rd_t              sb[$];
    int               errors = 0;
    int               checks = 0;
    int               exp_wait = 0;
    logic [31:0]      ca, na;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .cpu_wait_cnt_o(wait_cnt)
    );

    function automatic logic [DATA_W-1:0] rdata_of(logic [ADDR_W-1:0] a);
        return {~a, a};
    endfunction

    // Memory model: one-cycle read latency, data derived from the address.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.mem_rdata <= '0;
        else if (bus.mem_en && !bus.mem_wren) bus.mem_rdata <= rdata_of(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.nic_req = 1'b0; bus.nic_lock = 1'b0; bus.nic_we = 1'b0;
        bus.nic_addr = '0; bus.nic_wdata = '0;
    endtask

    task automatic check_rvalid_none(input string tag);
        check({tag, "/cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'd0);
        check({tag, "/nic_rvalid"}, 64'(bus.nic_rvalid), 64'd0);
    endtask

    task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic nreq, input logic nlock, input logic nwe,
                        input logic [31:0] naddr, input logic ecg, input logic eng,
                        input string tag);
        rd_t         e;
        logic [63:0] cwd, nwd, exp_addr, exp_wd;
        logic        exp_we;
        cwd = {32'hC0DE_0000, caddr};
        nwd = {32'h4E1C_0000, naddr};
        @(negedge clk);
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
        bus.nic_req = nreq; bus.nic_lock = nlock; bus.nic_we = nwe;
        bus.nic_addr = naddr; bus.nic_wdata = nwd;
        #1;
        exp_addr = ecg ? 64'(caddr) : eng ? 64'(naddr) : 64'd0;
        exp_wd   = ecg ? cwd : eng ? nwd : 64'd0;
        exp_we   = ecg ? cwe : eng ? nwe : 1'b0;
        check({tag, "/cpu_gnt"},   64'(bus.cpu_gnt),   64'(ecg));
        check({tag, "/nic_gnt"},   64'(bus.nic_gnt),   64'(eng));
        check({tag, "/cpu_stall"}, 64'(bus.cpu_stall), 64'(creq & ~ecg));
        check({tag, "/mem_en"},    64'(bus.mem_en),    64'(ecg | eng));
        check({tag, "/mem_wren"},  64'(bus.mem_wren),  64'(exp_we));
        check({tag, "/mem_addr"},  64'(bus.mem_addr),  exp_addr);
        check({tag, "/mem_wdata"}, bus.mem_wdata,      exp_wd);
        check({tag, "/wait_cnt"},  64'(wait_cnt),      64'(exp_wait));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "/cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'(!e.is_nic));
            check({tag, "/nic_rvalid"}, 64'(bus.nic_rvalid), 64'(e.is_nic));
            check({tag, "/rdata"}, e.is_nic ? bus.nic_rdata : bus.cpu_rdata, e.data);
        end else begin
            check_rvalid_none(tag);
        end
        if (creq && !ecg && exp_wait < (2**CNT_W - 1)) exp_wait++;
        if (ecg && !cwe) sb.push_back('{is_nic: 1'b0, data: rdata_of(caddr)});
        else if (eng && !nwe) sb.push_back('{is_nic: 1'b1, data: rdata_of(naddr)});
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        sb.delete();
        exp_wait = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check({tag, "/rst_mem_en"},   64'(bus.mem_en),    64'd0);
            check({tag, "/rst_gnt"},      64'({bus.cpu_gnt, bus.nic_gnt, bus.cpu_stall}), 64'd0);
            check({tag, "/rst_mem_bus"},  64'({bus.mem_wren, bus.mem_addr}), 64'd0);
            check({tag, "/rst_mem_wdata"}, bus.mem_wdata,     64'd0);
            check({tag, "/rst_rdata"},    bus.cpu_rdata | bus.nic_rdata, 64'd0);
            check({tag, "/rst_wait_cnt"}, 64'(wait_cnt),      64'd0);
            check_rvalid_none({tag, "/rst"});
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        // Reset with no requests.
        do_reset("t1");
        idle("t1_idle");

        // Lone CPU read.
        step(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "t2_rd");
        idle("t2_ret");

        // Continuous contention, no lock: C,N,C,N... starting with the CPU.
        do_reset("t3");
        ca = 32'h100; na = 32'h200;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, ca, 1'b1, 1'b0, 1'b0, na, (i % 2) == 0, (i % 2) == 1, "t3_rr");
            if (i % 2 == 0) ca++; else na++;
        end
        idle("t3_ret");

        // Locked NIC bursts against a held CPU request; counter saturates at 15.
        do_reset("t4");
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "t4_cwr");
        ca = 32'h500; na = 32'h600;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, ca, 1'b1, 1'b1, 1'b0, na, (i % 5) == 4, (i % 5) != 4, "t4_burst");
            if (i == 5) check("t4_wait_after_cgnt", 64'(wait_cnt), 64'd4);
            if (i % 5 == 4) ca++; else na++;
        end
        idle("t5_ret");
        check("t5_wait_saturated", 64'(wait_cnt), 64'd15);

        // Burst ended early by dropping nic_lock hands the next slot to the CPU.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 1'b1, "t7_lock");
        step(1'b1, 1'b0, 32'h710, 1'b1, 1'b0, 1'b0, 32'h701, 1'b0, 1'b1, "t7_unlock");
        step(1'b1, 1'b0, 32'h710, 1'b1, 1'b0, 1'b0, 32'h702, 1'b1, 1'b0, "t7_cpu");
        idle("t7_ret");

        // Reset mid-burst with a NIC read in flight.
        do_reset("t6a");
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 1'b1, "t6_nrd");
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive_idle();
        sb.delete();
        exp_wait = 0;
        #1;
        check_rvalid_none("t6_rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_rvalid_none("t6_rst_hold");
            check("t6_rst_mem_en", 64'(bus.mem_en), 64'd0);
        end
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h800, 1'b1, 1'b1, 1'b0, 32'h900, 1'b1, 1'b0, "t6_cpu_first");
        idle("t6_ret");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
